// File: rtl/vending_pkg.sv
// -----------------------------------------------------------------------------
// vending_pkg
// Shared definitions for the vending credit controller: FSM state encoding,
// coin values in quarter units and the default item price.
// -----------------------------------------------------------------------------
package vending_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_VEND    = 2'd2,
    ST_CHANGE  = 2'd3
  } vend_state_e;

  localparam int unsigned COIN_Q_VAL      = 32'd1;
  localparam int unsigned COIN_D_VAL      = 32'd4;
  localparam int unsigned PRICE_Q_DEFAULT = 32'd3;

endpackage

// File: rtl/vending_edge_det.sv
// -----------------------------------------------------------------------------
// vending_edge_det
// Rising-edge detector for one level input. The level is compared against a
// one-cycle-delayed registered copy, so a held level yields a single pulse.
// The delay register resets to 0, so a level already high when reset is
// released produces a pulse on the first clock edge.
//   clk     : system clock
//   rstn    : asynchronous active-low reset
//   level_i : input level
//   pulse_o : high for one cycle after a 0->1 transition of level_i
// -----------------------------------------------------------------------------
module vending_edge_det (
  input  logic clk,
  input  logic rstn,
  input  logic level_i,
  output logic pulse_o
);

  logic level_q;

  // Delayed copy of the input level used as the edge reference.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level_i;
    end
  end

  assign pulse_o = level_i & ~level_q;

endmodule

// File: rtl/vending_credit_ctrl.sv
// -----------------------------------------------------------------------------
// vending_credit_ctrl
// Coin credit controller: accumulates quarters/dollars, releases an item once
// credit reaches PRICE_Q, then returns any remainder one quarter at a time.
// A cancel while collecting refunds all credit without dispensing.
//   clk         : system clock
//   rstn        : asynchronous active-low reset
//   Q_in        : quarter coin level (one coin per rising edge)
//   D_in        : dollar coin level (one coin per rising edge)
//   cancel_in   : refund request level (acts on rising edge)
//   dispense    : one-cycle pulse, item released
//   change_q    : one pulse per quarter returned
//   coin_reject : one-cycle pulse, coin arrived while vending/returning change
//   busy        : high in VEND and CHANGE
//   credit      : current credit in quarters
// -----------------------------------------------------------------------------
module vending_credit_ctrl
  import vending_pkg::*;
#(
  parameter int unsigned PRICE_Q  = PRICE_Q_DEFAULT,
  parameter int unsigned CREDIT_W = 32'd4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                Q_in,
  input  logic                D_in,
  input  logic                cancel_in,
  output logic                dispense,
  output logic                change_q,
  output logic                coin_reject,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
);

  // One extra bit so credit + 5 never wraps before the price compare.
  localparam int unsigned       SUM_W   = CREDIT_W + 32'd1;
  localparam logic [SUM_W-1:0]  PRICE_V = SUM_W'(PRICE_Q);
  localparam logic [SUM_W-1:0]  Q_VAL   = SUM_W'(COIN_Q_VAL);
  localparam logic [SUM_W-1:0]  D_VAL   = SUM_W'(COIN_D_VAL);
  localparam logic [SUM_W-1:0]  ZERO_S  = SUM_W'(0);
  localparam logic [CREDIT_W-1:0] ONE_C = CREDIT_W'(1);

  logic q_evt_s, d_evt_s, c_evt_s, coin_evt_s;
  logic [SUM_W-1:0] sum_s;

  vend_state_e         state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                phase_q, phase_d;      // 1: change pulse just issued, low cycle due
  logic                dispense_q, dispense_d;
  logic                chg_q, chg_d;
  logic                reject_q, reject_d;
  logic                busy_q, busy_d;

  vending_edge_det u_edge_q (.clk(clk), .rstn(rstn), .level_i(Q_in),      .pulse_o(q_evt_s));
  vending_edge_det u_edge_d (.clk(clk), .rstn(rstn), .level_i(D_in),      .pulse_o(d_evt_s));
  vending_edge_det u_edge_c (.clk(clk), .rstn(rstn), .level_i(cancel_in), .pulse_o(c_evt_s));

  assign coin_evt_s = q_evt_s | d_evt_s;
  assign sum_s = {1'b0, credit_q}
               + (q_evt_s ? Q_VAL : ZERO_S)
               + (d_evt_s ? D_VAL : ZERO_S);

  // Next-state and next-output logic for the credit FSM.
  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    phase_d    = phase_q;
    dispense_d = 1'b0;
    chg_d      = 1'b0;
    reject_d   = 1'b0;
    case (state_q)
      ST_IDLE, ST_COLLECT: begin
        // Coins are added before the price check; a vend overrides cancel.
        if (sum_s >= PRICE_V) begin
          credit_d   = CREDIT_W'(sum_s - PRICE_V);
          state_d    = ST_VEND;
          dispense_d = 1'b1;
        end else if (c_evt_s && (state_q == ST_COLLECT)) begin
          credit_d = CREDIT_W'(sum_s);
          state_d  = ST_CHANGE;
          phase_d  = 1'b0;
        end else if (sum_s != ZERO_S) begin
          credit_d = CREDIT_W'(sum_s);
          state_d  = ST_COLLECT;
        end else begin
          credit_d = '0;
          state_d  = ST_IDLE;
        end
      end
      ST_VEND: begin
        reject_d = coin_evt_s;
        phase_d  = 1'b0;
        if (credit_q != '0) begin
          state_d = ST_CHANGE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHANGE: begin
        reject_d = coin_evt_s;
        // Alternate pulse/low cycles; leave only after a low cycle with no credit left.
        if (phase_q) begin
          phase_d = 1'b0;
        end else if (credit_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          chg_d    = 1'b1;
          credit_d = credit_q - ONE_C;
          phase_d  = 1'b1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        credit_d = '0;
        phase_d  = 1'b0;
      end
    endcase
    busy_d = (state_d == ST_VEND) || (state_d == ST_CHANGE);
  end

  // State, credit and registered output flops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      credit_q   <= '0;
      phase_q    <= 1'b0;
      dispense_q <= 1'b0;
      chg_q      <= 1'b0;
      reject_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      phase_q    <= phase_d;
      dispense_q <= dispense_d;
      chg_q      <= chg_d;
      reject_q   <= reject_d;
      busy_q     <= busy_d;
    end
  end

  assign dispense    = dispense_q;
  assign change_q    = chg_q;
  assign coin_reject = reject_q;
  assign busy        = busy_q;
  assign credit      = credit_q;

endmodule

// File: tb/tb_vending_credit_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vending_credit_ctrl
// Scoreboard bench: the driver applies coin/cancel transactions and a credit
// model pushes expected dispense/change/reject events into queues; a monitor
// pops and compares whenever the DUT pulses an output.
// -----------------------------------------------------------------------------
module tb_vending_credit_ctrl;

  localparam int PRICE = 3;

  logic       clk = 1'b0;
  logic       rstn;
  logic       q_in, d_in, cancel_in;
  logic       dispense, change_q, coin_reject, busy;
  logic [3:0] credit;

  int n_pass  = 0;
  int n_total = 0;

  int exp_disp[$];   // expected credit while dispense is high
  int exp_chg[$];    // expected credit while change_q is high
  int exp_rej[$];    // one entry per expected coin_reject pulse
  int model_credit = 0;

  vending_credit_ctrl #(.PRICE_Q(PRICE), .CREDIT_W(4)) dut (
    .clk(clk), .rstn(rstn), .Q_in(q_in), .D_in(d_in), .cancel_in(cancel_in),
    .dispense(dispense), .change_q(change_q), .coin_reject(coin_reject),
    .busy(busy), .credit(credit)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Credit model: quarters = 1, dollars = 4; vend at >= PRICE, remainder returned.
  task automatic model_apply(input bit q, input bit d, input bit c);
    int coins, total;
    coins = (q ? 1 : 0) + (d ? 4 : 0);
    total = model_credit + coins;
    if (total >= PRICE) begin
      exp_disp.push_back(total - PRICE);
      for (int k = total - PRICE - 1; k >= 0; k--) exp_chg.push_back(k);
      model_credit = 0;
    end else if (c && model_credit > 0) begin
      for (int k = total - 1; k >= 0; k--) exp_chg.push_back(k);
      model_credit = 0;
    end else begin
      model_credit = total;
    end
  endtask

  // Monitor: every output pulse must match the head of its queue.
  always @(negedge clk) begin
    if (dispense) begin
      check("disp_expected", int'(exp_disp.size() > 0), 1);
      if (exp_disp.size() > 0) check("disp_credit", int'(credit), exp_disp.pop_front());
      check("disp_chg_excl", int'(change_q), 0);
    end
    if (change_q) begin
      check("chg_expected", int'(exp_chg.size() > 0), 1);
      if (exp_chg.size() > 0) check("chg_credit", int'(credit), exp_chg.pop_front());
    end
    if (coin_reject) begin
      check("rej_expected", int'(exp_rej.size() > 0), 1);
      if (exp_rej.size() > 0) void'(exp_rej.pop_front());
    end
  end

  task automatic wait_idle();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("idle_reached", int'(busy), 0);
  endtask

  task automatic check_drained();
    check("disp_drained", exp_disp.size(), 0);
    check("chg_drained",  exp_chg.size(),  0);
    check("rej_drained",  exp_rej.size(),  0);
  endtask

  // One coin/cancel transaction: raise levels, hold, drop, wait for completion.
  task automatic coin(input bit q, input bit d, input bit c, input int hold);
    @(posedge clk); #2;
    q_in = q; d_in = d; cancel_in = c;
    model_apply(q, d, c);
    repeat (hold) @(posedge clk);
    #2;
    q_in = 1'b0; d_in = 1'b0; cancel_in = 1'b0;
    wait_idle();
    check("credit_after", int'(credit), model_credit);
    check_drained();
  endtask

  task automatic reject_during_change();
    @(posedge clk); #2;
    q_in = 1'b1; d_in = 1'b1;
    model_apply(1'b1, 1'b1, 1'b0);
    @(posedge clk); #2;
    q_in = 1'b0; d_in = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (change_q) break;
    end
    check("chg_first_seen", int'(change_q), 1);
    q_in = 1'b1;
    exp_rej.push_back(1);
    @(posedge clk); #2;
    q_in = 1'b0;
    wait_idle();
    check("credit_after_rej", int'(credit), 0);
    check_drained();
  endtask

  task automatic reset_mid_change();
    int seen;
    seen = 0;
    @(posedge clk); #2;
    q_in = 1'b1; d_in = 1'b1;
    model_apply(1'b1, 1'b1, 1'b0);
    @(posedge clk); #2;
    q_in = 1'b0; d_in = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (change_q) begin
        seen++;
        if (seen == 2) break;
      end
    end
    check("chg_second_seen", seen, 2);
    #1 rstn = 1'b0;
    #1 check("rst_outputs", int'({dispense, change_q, coin_reject, busy, credit}), 0);
    exp_disp.delete(); exp_chg.delete(); exp_rej.delete();
    model_credit = 0;
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_credit", int'(credit), 0);
    check("post_rst_busy", int'(busy), 0);
  endtask

  task automatic level_at_release();
    @(posedge clk); #2;
    rstn = 1'b0;
    q_in = 1'b1;
    @(posedge clk); #2;
    rstn = 1'b1;
    model_apply(1'b1, 1'b0, 1'b0);
    @(posedge clk); #2;
    q_in = 1'b0;
    wait_idle();
    check("credit_level_release", int'(credit), model_credit);
    coin(1'b0, 1'b0, 1'b1, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit rq, rd, rc;
    rstn = 1'b0; q_in = 1'b0; d_in = 1'b0; cancel_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("reset_outputs", int'({dispense, change_q, coin_reject, busy, credit}), 0);
    @(posedge clk); #2 rstn = 1'b1;

    // Dollar held 10 cycles: one vend, one quarter back.
    coin(1'b0, 1'b1, 1'b0, 10);
    // Three separate quarters.
    coin(1'b1, 1'b0, 1'b0, 1);
    coin(1'b1, 1'b0, 1'b0, 2);
    coin(1'b1, 1'b0, 1'b0, 1);
    // Quarter and dollar together: credit 5, two quarters back.
    coin(1'b1, 1'b1, 1'b0, 1);
    // Two quarters then cancel: two quarters back, no vend.
    coin(1'b1, 1'b0, 1'b0, 1);
    coin(1'b1, 1'b0, 1'b0, 1);
    coin(1'b0, 1'b0, 1'b1, 1);
    // Cancel in IDLE is ignored.
    coin(1'b0, 1'b0, 1'b1, 1);
    reject_during_change();
    reset_mid_change();
    level_at_release();

    for (int i = 0; i < 40; i++) begin
      rq = 1'($urandom_range(0, 1));
      rd = ($urandom_range(0, 3) == 0);
      rc = ($urandom_range(0, 3) == 0);
      coin(rq, rd, rc, $urandom_range(1, 3));
    end

    check_drained();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vending_credit_ctrl.md
VENDING_CREDIT_CTRL -- requirements
Module: vending_credit_ctrl

Interface
REQ-001 The block SHALL have parameter PRICE_Q, default 3, meaning item price in quarters (legal 1..12).
REQ-002 The block SHALL have parameter CREDIT_W, default 4, meaning credit register width.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  system clock; all state updates on its rising edge.
REQ-005 rstn  input  1  asynchronous active-low reset.
REQ-006 Q_in  input  1  quarter coin level; one coin per 0->1 transition.
REQ-007 D_in  input  1  dollar coin level; one coin per 0->1 transition.
REQ-008 cancel_in  input  1  level; 0->1 transition requests refund of all credit.
REQ-009 dispense  output  1  one-cycle pulse; item released.
REQ-010 change_q  output  1  one pulse per quarter returned.
REQ-011 coin_reject  output  1  one-cycle pulse; coin edge arrived while not accepting.
REQ-012 busy  output  1  high in VEND and CHANGE states.
REQ-013 credit  output  CREDIT_W  current accumulated credit in quarters.

Function
REQ-014 Coin/cancel events SHALL be 0->1 transitions detected against a one-cycle-delayed registered copy; a held level SHALL count once.
REQ-015 Coin values SHALL be quarter = 1, dollar = 4 (quarter units).
REQ-016 FSM states SHALL be IDLE, COLLECT, VEND, CHANGE.
REQ-017 IDLE/COLLECT: on the edge sampling coin event(s), credit SHALL become credit + sum of coins; Q and D edges in the same cycle SHALL both count (+5).
REQ-018 If updated credit < PRICE_Q, state SHALL be COLLECT (credit>0) and stay there.
REQ-019 If updated credit >= PRICE_Q, the same edge SHALL load credit - PRICE_Q and enter VEND; dispense SHALL be high for exactly the next cycle.
REQ-020 VEND SHALL last one cycle, then go to CHANGE if credit > 0, else IDLE.
REQ-021 CHANGE: change_q SHALL pulse high one cycle, low one cycle, decrementing credit by 1 per pulse; exit to IDLE when credit reaches 0 after the final low cycle.
REQ-022 cancel edge in COLLECT SHALL enter CHANGE with current credit and no dispense; cancel in IDLE SHALL be ignored.
REQ-023 Coin and cancel edges in same COLLECT cycle: coins SHALL be added first, then price check; cancel SHALL be ignored if a vend occurs, otherwise CHANGE refunds the updated credit.
REQ-024 Coin edges in VEND or CHANGE SHALL NOT alter credit and SHALL assert coin_reject for one cycle.
REQ-025 credit SHALL never exceed PRICE_Q + 3; no overflow possible with CREDIT_W = 4 and PRICE_Q <= 12.
REQ-026 dispense and change_q SHALL be registered outputs, never high in the same cycle.

Reset
REQ-027 rstn low SHALL immediately force state IDLE, credit 0, dispense 0, change_q 0, coin_reject 0, busy 0, edge-detect registers 0.
REQ-028 Reset mid-VEND or mid-CHANGE SHALL discard remaining credit with no further pulses.
REQ-029 After rstn release, a level already high on Q_in/D_in SHALL count as a coin on the first edge (delay registers reset to 0).

Structure
REQ-030 Package vending_pkg SHALL hold the state enum, COIN_Q_VAL = 1, COIN_D_VAL = 4, default PRICE_Q.
REQ-031 Edge detection SHALL be one sub-module, vending_edge_det (one instance per input, one-cycle pulse out).
REQ-032 Interface SHALL be compatible with the existing vending_machine_interface signal names (rstn, Q_in, D_in).

Verification (PRICE_Q = 3)
REQ-033 D_in 0->1 held 10 cycles -> one dispense pulse, one change_q pulse, credit back to 0, IDLE.
REQ-034 Three separate Q_in pulses -> credit 1, 2, then dispense, zero change_q pulses.
REQ-035 Q_in and D_in rise same cycle -> credit 5 -> dispense, then two change_q pulses.
REQ-036 Two quarters then cancel_in -> no dispense, two change_q pulses, IDLE.
REQ-037 Q_in edge during CHANGE -> coin_reject pulse, change_q count unchanged.
REQ-038 rstn low during second change_q pulse of REQ-035 -> all outputs 0 immediately, no further pulses after release.
